// File: rtl/apb_requester.sv
// APB requester: 2-entry command FIFO feeding an IDLE/SETUP/ACCESS master FSM.
// Define APB_REQ_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles of PREADY low.
module apb_requester #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q;
    logic              psel_q, penable_q, pwrite_q, rsp_valid_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;

    logic              fifo_write_q [2];
    logic [ADDR_W-1:0] fifo_addr_q  [2];
    logic [DATA_W-1:0] fifo_wdata_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q, count_d;

    logic push, pop, has_cmd, done, timeout_hit;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign cmd_ready  = (count_q != 2'd2);
    assign has_cmd    = (count_q != 2'd0);
    assign push       = cmd_valid && cmd_ready;
    assign done       = (state_q == StAccess) && (PREADY || timeout_hit);
    // The FSM takes a new command from IDLE or straight out of a completing ACCESS.
    assign pop        = has_cmd && ((state_q == StIdle) || done);
    assign head_write = fifo_write_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= cmd_write;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (has_cmd) begin
                        state_q   <= StSetup;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= head_write;
                        paddr_q   <= head_addr;
                        pwdata_q  <= head_wdata;
                    end
                end
                StSetup: begin
                    state_q   <= StAccess;
                    penable_q <= 1'b1;
                end
                StAccess: begin
                    if (done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (pwrite_q || !PREADY) ? '0 : PRDATA;
                        penable_q   <= 1'b0;
                        if (has_cmd) begin
                            state_q  <= StSetup;
                            pwrite_q <= head_write;
                            paddr_q  <= head_addr;
                            pwdata_q <= head_wdata;
                        end else begin
                            state_q <= StIdle;
                            psel_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef APB_REQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q;
    logic            rsp_err_q;

    assign timeout_hit = !PREADY && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= done && timeout_hit;
            if (pop) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == StAccess) && !PREADY && !timeout_hit) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed and randomized bench for apb_requester with a queue-based scoreboard.
module tb_apb_requester;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] PADDR, PWDATA, PRDATA, rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, rsp_valid, rsp_err;
    logic        PREADY = 1'b0;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } cmd_t;

    int n_cmp = 0;
    int n_bad = 0;

    apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 PCLK = ~PCLK;

    // Completer memory model: address 4 returns 0x2A, others a scrambled address.
    function automatic logic [31:0] compl_data(input logic [31:0] a);
        return (a == 32'h4) ? 32'h0000_002A : (a ^ 32'h5A5A_0000);
    endfunction

    assign PRDATA = compl_data(PADDR);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, PSEL, 0);
        chk({tag, "_penable"}, PENABLE, 0);
        chk({tag, "_pwrite"}, PWRITE, 0);
        chk({tag, "_paddr"}, PADDR, 0);
        chk({tag, "_pwdata"}, PWDATA, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    localparam int NR = 40;
    cmd_t        pend[$];
    cmd_t        cur, nxt;
    logic [31:0] t3_addr [3];
    int          pulses, acc_cycles, pre, rsps, issued;
    logic        seen, drove, mready, pr_applied, prev_acc, prev_write, prev_psel;
    logic [31:0] prev_addr, prev_wdata;

    initial begin
        // Reset state
        @(negedge PCLK);
        chk_all_zero("reset");

        // Single write, PREADY tied high
        PRESET = 1'b0;
        PREADY = 1'b1;
        offer(1'b1, 32'h10, 32'hA5A5_0001);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("w_e0_psel", PSEL, 0);
        @(negedge PCLK);
        chk("w_e1_psel", PSEL, 1);
        chk("w_e1_penable", PENABLE, 0);
        chk("w_e1_paddr", PADDR, 32'h10);
        chk("w_e1_pwrite", PWRITE, 1);
        chk("w_e1_pwdata", PWDATA, 32'hA5A5_0001);
        @(negedge PCLK);
        chk("w_e2_penable", PENABLE, 1);
        chk("w_e2_rsp_valid", rsp_valid, 0);
        @(negedge PCLK);
        chk("w_e3_rsp_valid", rsp_valid, 1);
        chk("w_e3_rsp_err", rsp_err, 0);
        chk("w_e3_rsp_rdata", rsp_rdata, 0);
        chk("w_e3_psel", PSEL, 0);
        @(negedge PCLK);
        chk("w_e4_rsp_valid", rsp_valid, 0);
        chk("w_e4_paddr_hold", PADDR, 32'h10);

        // Read with three wait states
        PREADY = 1'b0;
        offer(1'b0, 32'h4, 32'hDEAD_BEEF);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("r_setup_psel", PSEL, 1);
        chk("r_setup_pwrite", PWRITE, 0);
        chk("r_setup_paddr", PADDR, 32'h4);
        @(negedge PCLK);
        chk("r_access_penable", PENABLE, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("r_wait_psel", PSEL, 1);
            chk("r_wait_penable", PENABLE, 1);
            chk("r_wait_paddr", PADDR, 32'h4);
            chk("r_wait_pwrite", PWRITE, 0);
            chk("r_wait_rsp_valid", rsp_valid, 0);
        end
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_rdata", rsp_rdata, 32'h2A);
        @(negedge PCLK);
        chk("r_rsp_one_cycle", rsp_valid, 0);
        chk("r_rdata_hold", rsp_rdata, 32'h2A);
        chk("r_idle_penable", PENABLE, 0);
        chk("r_idle_paddr", PADDR, 32'h4);

        // Three back-to-back commands
        t3_addr[0] = 32'h100;
        t3_addr[1] = 32'h104;
        t3_addr[2] = 32'h108;
        PREADY = 1'b0;
        offer(1'b0, t3_addr[0], 32'h0);
        @(negedge PCLK);
        chk("b_ready_e0", cmd_ready, 1);
        offer(1'b0, t3_addr[1], 32'h0);
        @(negedge PCLK);
        chk("b_ready_e1", cmd_ready, 1);
        chk("b_psel_e1", PSEL, 1);
        offer(1'b0, t3_addr[2], 32'h0);
        @(negedge PCLK);
        chk("b_full", cmd_ready, 0);
        cmd_valid = 1'b0;
        PREADY = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20 && pulses < 3; c++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                chk("b_rdata_order", rsp_rdata, compl_data(t3_addr[pulses]));
                pulses++;
            end
            if (pulses < 3) chk("b_no_gap", PSEL, 1);
        end
        chk("b_pulses", pulses, 3);
        chk("b_idle_after", PSEL, 0);

        // Reset during ACCESS with one command queued
        PREADY = 1'b0;
        offer(1'b1, 32'h200, 32'h11);
        @(negedge PCLK);
        offer(1'b1, 32'h300, 32'h22);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("x_access", PENABLE, 1);
        chk("x_one_queued", cmd_ready, 1);
        @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        chk_all_zero("x_async");
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge PCLK);
            if (PSEL || rsp_valid) seen = 1'b1;
        end
        chk("x_discarded", seen, 0);

`ifdef APB_REQ_TIMEOUT_EN
        PREADY = 1'b0;
        offer(1'b1, 32'h40, 32'h55);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        acc_cycles = 0;
        for (int c = 0; c < 40 && !rsp_valid; c++) begin
            if (PENABLE) acc_cycles++;
            @(negedge PCLK);
        end
        chk("t_rsp_valid", rsp_valid, 1);
        chk("t_acc_cycles", acc_cycles, 16);
        chk("t_rsp_err", rsp_err, 1);
        chk("t_rsp_rdata", rsp_rdata, 0);
        chk("t_psel", PSEL, 0);
        @(negedge PCLK);
        chk("t_one_cycle", rsp_valid, 0);
        PREADY = 1'b1;
`else
        PREADY = 1'b0;
        offer(1'b1, 32'h40, 32'h55);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge PCLK);
            if (rsp_valid || rsp_err) seen = 1'b1;
        end
        chk("n_no_rsp", seen, 0);
        chk("n_psel", PSEL, 1);
        chk("n_penable", PENABLE, 1);
        chk("n_rsp_err", rsp_err, 0);
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("n_late_rsp", rsp_valid, 1);
`endif
        repeat (3) @(negedge PCLK);

        // Randomized traffic against a queue scoreboard
        rsps   = 0;
        issued = 0;
        for (int cyc = 0; cyc < 3000 && rsps < NR; cyc++) begin
            if (!cmd_valid && issued < NR && $urandom_range(0, 2) != 0) begin
                nxt.w = 1'($urandom_range(0, 1));
                nxt.a = $urandom & 32'hFFFF_FFFC;
                nxt.d = $urandom;
                offer(nxt.w, nxt.a, nxt.d);
                issued++;
            end
            mready     = (pend.size() < 2);
            drove      = cmd_valid;
            PREADY     = ($urandom_range(0, 2) != 0);
            pr_applied = PREADY;
            prev_acc   = PSEL && PENABLE;
            prev_psel  = PSEL;
            prev_addr  = PADDR;
            prev_write = PWRITE;
            prev_wdata = PWDATA;
            @(negedge PCLK);
            pre = pend.size();
            if (drove && mready) begin
                pend.push_back(nxt);
                cmd_valid = 1'b0;
            end
            if (prev_acc && !pr_applied) begin
                chk("q_wait_psel", PSEL, prev_psel);
                chk("q_wait_penable", PENABLE, 1);
                chk("q_wait_paddr", PADDR, prev_addr);
                chk("q_wait_pwrite", PWRITE, prev_write);
                chk("q_wait_pwdata", PWDATA, prev_wdata);
                chk("q_wait_rsp", rsp_valid, 0);
            end else if (prev_acc) begin
                chk("q_rsp_valid", rsp_valid, 1);
                chk("q_rsp_rdata", rsp_rdata, cur.w ? 32'h0 : compl_data(cur.a));
                chk("q_rsp_err", rsp_err, 0);
                rsps++;
            end else begin
                chk("q_no_rsp", rsp_valid, 0);
            end
            if (PSEL && !PENABLE) begin
                chk("q_pop_nonempty", pre > 0, 1);
                if (pend.size() > 0) begin
                    cur = pend.pop_front();
                    chk("q_paddr", PADDR, cur.a);
                    chk("q_pwrite", PWRITE, cur.w);
                    chk("q_pwdata", PWDATA, cur.d);
                end
            end
            if (PENABLE) chk("q_penable_psel", PSEL, 1);
            chk("q_cmd_ready", cmd_ready, pend.size() < 2);
        end
        chk("q_all_done", rsps, NR);
        chk("q_drained", pend.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles with PREADY low before abort (used only with APB_REQ_TIMEOUT_EN).
REQ-004 SHALL have port PCLK  in  1  as the single clock; all logic is on the rising edge.
REQ-005 SHALL have port PRESET  in  1  as the asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  in  1  as the command request.
REQ-007 SHALL have port cmd_ready  out  1  as the command accept; the transfer occurs when cmd_valid and cmd_ready are both high at a PCLK edge.
REQ-008 SHALL have port cmd_write  in  1  with 1 = write and 0 = read.
REQ-009 SHALL have ports cmd_addr  in  ADDR_W and cmd_wdata  in  DATA_W as the command address and write data.
REQ-010 SHALL have ports PADDR  out  ADDR_W, PSEL  out  1, PENABLE  out  1, PWRITE  out  1 and PWDATA  out  DATA_W as the APB request outputs.
REQ-011 SHALL have ports PRDATA  in  DATA_W and PREADY  in  1 as the APB completer response inputs.
REQ-012 SHALL have ports rsp_valid  out  1 (one-cycle completion pulse), rsp_rdata  out  DATA_W (read data) and rsp_err  out  1 (timeout flag).

Function
REQ-013 SHALL buffer commands in a 2-entry FIFO; cmd_ready = FIFO not full; cmd_ready is combinational from FIFO state only.
REQ-014 SHALL implement FSM states IDLE, SETUP and ACCESS; all APB outputs are registered.
REQ-015 IDLE with FIFO non-empty SHALL pop the head and go to SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA loaded from the head.
REQ-016 SETUP SHALL always go to ACCESS on the next edge: PENABLE=1; PADDR/PWRITE/PWDATA held stable.
REQ-017 ACCESS with PREADY=0 SHALL hold all APB outputs unchanged.
REQ-018 ACCESS with PREADY=1 SHALL complete the transfer: rsp_valid=1 for exactly one cycle; rsp_rdata=PRDATA for reads and 0 for writes; rsp_err=0.
REQ-019 On completion with FIFO non-empty, SHALL go directly to SETUP with the next command (PSEL stays 1, PENABLE=0): back-to-back transfers with no idle cycle.
REQ-020 On completion with FIFO empty, SHALL go to IDLE with PSEL=0 and PENABLE=0.
REQ-021 Latency: for a command accepted at edge E0 into an empty FIFO while IDLE, SETUP SHALL be visible after E1, ACCESS after E2, and rsp_valid after E3 if PREADY=1 at E3.
REQ-022 A push and a pop in the same cycle SHALL both take effect, with the occupancy unchanged.
REQ-023 When no transfer is in progress, PADDR, PWRITE and PWDATA SHALL hold their last values and PENABLE SHALL be 0.
REQ-024 rsp_rdata SHALL hold its value between rsp_valid pulses.

Reset
REQ-025 PRESET high SHALL immediately clear: FSM=IDLE, FIFO empty, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and timeout counter=0.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid, and SHALL discard queued commands.
REQ-027 The first command after reset deassertion SHALL follow REQ-021 timing.

Configuration
REQ-028 With macro APB_REQ_TIMEOUT_EN defined, SHALL count consecutive ACCESS cycles with PREADY=0.
REQ-029 When that count reaches TIMEOUT_CYCLES, SHALL end the transfer with rsp_valid=1, rsp_err=1 and rsp_rdata=0, then proceed per REQ-019/REQ-020.
REQ-030 The timeout counter SHALL clear on entry to SETUP.
REQ-031 Without APB_REQ_TIMEOUT_EN, ACCESS SHALL wait indefinitely for PREADY, rsp_err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-032 Bench SHALL cover: single write addr=0x10 data=0xA5A5_0001, PREADY tied 1 -> PSEL after E1, PENABLE after E2, rsp_valid after E3, rsp_err=0.
REQ-033 Bench SHALL cover: read addr=0x04, PRDATA=0x0000_002A, PREADY low for 3 ACCESS cycles -> APB outputs stable for 3 cycles, rsp_rdata=0x2A with a one-cycle rsp_valid.
REQ-034 Bench SHALL cover: 3 commands offered back-to-back -> cmd_ready low after 2 are queued; transfers run with no PSEL=0 gap between them; 3 rsp_valid pulses in order.
REQ-035 Bench SHALL cover: PRESET pulsed during ACCESS with 1 command queued -> all outputs 0 immediately, no rsp_valid, and the queued command is never issued.
REQ-036 Bench SHALL cover, with APB_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0, then PSEL=0.
REQ-037 Bench SHALL cover, without APB_REQ_TIMEOUT_EN, PREADY held 0 for 100 cycles -> still in ACCESS, rsp_valid=0, rsp_err=0.
